clip_recorder: RTL and testbench

Captures a triggered clip of incoming audio samples into the clip buffer that the sample players read from. It sits between the audio receive path (one 16-bit sample strobe per sample period, on `mclk`) and the write port of the clip RAM. It is the writer end of the clip buffer interface. Once armed, it waits for a sample whose magnitude reaches a programmable threshold. It then writes exactly `CLIP_LEN` consecutive samples, starting at address 0, and reports completion.

---
 rtl/clip_recorder.sv | 157 +++++++++++++++
 tb/tb_clip_recorder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clip_recorder.sv
// clip_recorder
//
// Captures one triggered clip of audio samples into the clip RAM.
// After an arm request it waits for a sample whose magnitude reaches
// `threshold`. It then writes exactly CLIP_LEN consecutive samples at
// addresses 0..CLIP_LEN-1 and parks in DONE until it is re-armed.
//
// Parameters
//   CLIP_LEN      clip length in samples (power of two, >= 2)
//   AW            address width, derived from CLIP_LEN
//
// Ports
//   mclk          master clock, the only clock
//   rst_n         synchronous active-low reset
//   arm           one-cycle request to start a new capture
//   abort         one-cycle cancel; overrides every other input
//   threshold     unsigned trigger magnitude (15 bits)
//   in_sample     signed 16-bit input sample
//   in_valid      one-cycle strobe qualifying in_sample
//   wr_en         clip RAM write enable (one pulse per stored sample)
//   wr_addr       clip RAM write address
//   wr_data       clip RAM write data (sample, unmodified)
//   busy          high while ARMED or RECORD
//   done          high while DONE
//   sample_count  samples written in the current capture
//
// All outputs are registered. A sample accepted at edge N is presented
// on the write port during cycle N+1.

// Saturating magnitude: |x| for a 16-bit two's-complement sample.
// -32768 has no positive counterpart, so it clamps to 32767.
module clip_recorder_mag (
    input  logic [15:0] sample,
    output logic [15:0] mag
);
    always_comb begin
        if (sample == 16'h8000)
            mag = 16'h7fff;
        else if (sample[15])
            mag = ~sample + 16'd1;
        else
            mag = sample;
    end
endmodule

module clip_recorder #(
    parameter int CLIP_LEN = 256,
    parameter int AW       = $clog2(CLIP_LEN)
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          abort,
    input  logic [14:0]   threshold,
    input  logic [15:0]   in_sample,
    input  logic          in_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   sample_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RECORD = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Count value held just before the write that completes the clip.
    localparam logic [AW:0] LAST_IDX = (AW+1)'(CLIP_LEN - 1);

    state_t        state_q, state_d;
    logic          wr_en_d;
    logic [AW-1:0] wr_addr_d;
    logic [15:0]   wr_data_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   mag;
    logic          trig;

    clip_recorder_mag u_mag (
        .sample (in_sample),
        .mag    (mag)
    );

    assign trig = (mag >= {1'b0, threshold});

    // Next-state and next-output logic. Address/data hold their last
    // value when no write happens; consumers qualify them with wr_en.
    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        cnt_d     = cnt_q;

        if (abort) begin
            // Cancel drops any same-cycle sample and keeps the partial count.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                    end
                end
                S_ARMED: begin
                    if (in_valid && trig) begin
                        // Triggering sample is the first one stored. CLIP_LEN
                        // is at least 2, so this write never completes a clip.
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = in_sample;
                        cnt_d     = (AW+1)'(1);
                        state_d   = S_RECORD;
                    end
                end
                S_RECORD: begin
                    if (in_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[AW-1:0];
                        wr_data_d = in_sample;
                        cnt_d     = cnt_q + (AW+1)'(1);
                        if (cnt_q == LAST_IDX)
                            state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decoded from the state register only, so these stay registered.
    assign busy         = (state_q == S_ARMED) || (state_q == S_RECORD);
    assign done         = (state_q == S_DONE);
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_clip_recorder.sv
module tb_clip_recorder;

    localparam int CLIP_LEN = 8;
    localparam int AW       = 3;

    logic          mclk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic          abort;
    logic [14:0]   threshold;
    logic [15:0]   in_sample;
    logic          in_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   sample_count;

    clip_recorder #(.CLIP_LEN(CLIP_LEN)) dut (
        .mclk         (mclk),
        .rst_n        (rst_n),
        .arm          (arm),
        .abort        (abort),
        .threshold    (threshold),
        .in_sample    (in_sample),
        .in_valid     (in_valid),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    // Reference model: the capture is either not running, waiting for a
    // loud enough sample, filling the clip, or holding a finished clip.
    bit waiting;   // armed, no trigger yet
    bit filling;   // trigger seen, clip not yet full
    bit finished;  // clip full
    int stored;    // samples stored in the current capture

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int magnitude(input logic [15:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    // Applies one cycle of inputs to the model; returns whether a write
    // is expected on the next cycle (and queues it for the monitor).
    function automatic bit model(input bit r, input bit a, input bit ab,
                                 input bit v, input logic [15:0] s,
                                 input logic [14:0] thr);
        bit w = 1'b0;
        if (!r) begin
            waiting = 0; filling = 0; finished = 0; stored = 0;
        end else if (ab) begin
            waiting = 0; filling = 0; finished = 0;
        end else if (waiting) begin
            if (v && magnitude(s) >= int'(thr)) begin
                exp_q.push_back('{addr: '0, data: s});
                w = 1'b1; stored = 1; waiting = 0; filling = 1;
            end
        end else if (filling) begin
            if (v) begin
                exp_q.push_back('{addr: AW'(stored), data: s});
                w = 1'b1; stored = stored + 1;
                if (stored == CLIP_LEN) begin
                    filling = 0; finished = 1;
                end
            end
        end else if (a) begin
            waiting = 1; finished = 0; stored = 0;
        end
        return w;
    endfunction

    task automatic step(input bit r, input bit a, input bit ab,
                        input bit v, input logic [15:0] s);
        bit ew;
        rst_n = r; arm = a; abort = ab; in_valid = v; in_sample = s;
        ew = model(r, a, ab, v, s, threshold);
        @(posedge mclk);
        #1;
        chk("wr_en", int'(wr_en), int'(ew));
        chk("busy", int'(busy), int'(waiting || filling));
        chk("done", int'(done), int'(finished));
        chk("sample_count", int'(sample_count), stored);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 16'h0);
    endtask

    // Monitor: pops the expected write whenever the DUT writes.
    always @(negedge mclk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", int'(wr_addr), int'(e.addr));
                chk("wr_data", int'(wr_data), int'(e.data));
            end
        end
    end

    initial begin
        logic [15:0] samp;
        threshold = 15'd0;
        waiting = 0; filling = 0; finished = 0; stored = 0;

        // Reset with arm / in_valid toggling
        step(0, 1, 0, 1, 16'h1234);
        step(0, 0, 0, 0, 16'h4321);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);

        // Threshold trigger: 10, -999 miss; -1000 triggers
        threshold = 15'd1000;
        step(1, 1, 0, 0, 16'h0);
        step(1, 0, 0, 1, 16'd10);       idle(3);
        step(1, 0, 0, 1, -16'sd999);    idle(3);
        step(1, 0, 0, 1, -16'sd1000);   idle(3);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 1, 16'($urandom)); idle(2);
        end
        chk("clip_done_count", int'(sample_count), CLIP_LEN);
        step(1, 0, 0, 1, 16'h7777);     // ignored in DONE

        // Saturation: 32766 misses, -32768 clamps to 32767 and triggers
        threshold = 15'd32767;
        step(1, 1, 0, 0, 16'h0);
        step(1, 0, 0, 1, 16'd32766);
        step(1, 0, 0, 1, 16'h8000);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 16'($urandom));

        // Zero threshold: sample 0 triggers; arm in DONE restarts
        threshold = 15'd0;
        step(1, 1, 0, 0, 16'h0);
        step(1, 0, 0, 1, 16'h0);
        chk("zero_thr_trig", int'(busy), 1);

        // Back-to-back: 12 consecutive strobes, only 8 stored
        idle(1);
        step(1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 16'(i + 1)); // finish prior
        step(1, 1, 0, 0, 16'h0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 1, 16'(16'h100 + i));
        chk("b2b_done", int'(done), 1);

        // Abort with in_valid after 3 writes
        step(1, 1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 16'(16'h200 + i));
        step(1, 0, 1, 1, 16'h2ff);
        chk("abort_count", int'(sample_count), 3);

        // arm during RECORD ignored; arm+abort -> IDLE
        step(1, 1, 0, 0, 16'h0);
        step(1, 0, 0, 1, 16'h300);
        step(1, 1, 0, 1, 16'h301);
        step(1, 1, 1, 0, 16'h0);
        chk("arm_abort_idle", int'(busy), 0);

        // Reset mid-RECORD
        step(1, 1, 0, 0, 16'h0);
        step(1, 0, 0, 1, 16'h400);
        step(1, 0, 0, 1, 16'h401);
        step(0, 0, 0, 1, 16'h402);
        step(1, 0, 0, 1, 16'h403);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 60) == 0) begin
                case ($urandom_range(0, 3))
                    0: threshold = 15'd0;
                    1: threshold = 15'd32767;
                    2: threshold = 15'($urandom_range(0, 200));
                    default: threshold = 15'($urandom);
                endcase
            end
            case ($urandom_range(0, 7))
                0: samp = 16'h8000;
                1: samp = 16'h7fff;
                2: samp = 16'($urandom_range(0, 400)) - 16'd200;
                default: samp = 16'($urandom);
            endcase
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 2) != 0),
                 samp);
        end

        idle(2);
        chk("pending_writes", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
